bram_stream_reader: RTL and testbench

Streams a contiguous run of words out of a `BRAM_inst` instance (simple dual-port, 1-cycle registered read) onto a valid/ready stream. It is the read-side counterpart to the BRAM write path. A controller issues `start` with a base address and a length. The block drives the RAM read address, absorbs the RAM read latency in a 2-entry buffer, and presents words in address order with full backpressure support and one word per cycle sustained throughput.

---
 rtl/bram_stream_reader_if.sv | 12 +
 rtl/bram_stream_reader.sv | 146 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream from the BRAM reader to its consumer.
interface bram_stream_reader_if #(
   parameter int DATA_WIDTH = 128
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a contiguous (wrapping) run of BRAM words onto a valid/ready stream,
// absorbing the one-cycle RAM read latency in a two-entry head/tail buffer.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a transfer
// RUN   | issuing reads, one per cycle while buffer credit allows
// DRAIN | all reads issued, emptying the buffer until the last beat pops
module bram_stream_reader #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] ram_data,
   bram_stream_reader_if.master  m
);
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   len_r;
   logic [ADDR_WIDTH:0]   issued;
   logic [ADDR_WIDTH:0]   captured;
   logic                  in_flight;
   logic                  hd_valid, hd_last, tl_valid, tl_last;
   logic [DATA_WIDTH-1:0] hd_data, tl_data;

   logic [ADDR_WIDTH:0]   len_sat;
   logic                  pop, issue, push_last;
   logic [1:0]            load;

   assign len_sat   = (len > DEPTH) ? DEPTH : len;
   assign pop       = hd_valid & m.ready;
   assign load      = {1'b0, hd_valid} + {1'b0, tl_valid} + {1'b0, in_flight};
   // read_addr already holds the next address; an issue just commits the RAM read of it
   assign issue     = (state == RUN) && (issued != len_r) && (load < (2'd2 + {1'b0, pop}));
   assign push_last = (captured == (len_r - 1'b1));

   assign m.valid = hd_valid;
   assign m.data  = hd_data;
   assign m.last  = hd_valid & hd_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         read_addr <= '0;
         len_r     <= '0;
         issued    <= '0;
         captured  <= '0;
         in_flight <= 1'b0;
         hd_valid  <= 1'b0;
         hd_last   <= 1'b0;
         hd_data   <= '0;
         tl_valid  <= 1'b0;
         tl_last   <= 1'b0;
         tl_data   <= '0;
      end else begin
         done      <= 1'b0;
         in_flight <= issue;

         if (issue) begin
            issued <= issued + 1'b1;
            if ((issued + 1'b1) != len_r)
               read_addr <= read_addr + 1'b1;
         end

         if (in_flight)
            captured <= captured + 1'b1;

         // Credit check guarantees a slot exists whenever in_flight data lands
         case ({pop, in_flight})
            2'b11: begin
               if (tl_valid) begin
                  hd_data <= tl_data;
                  hd_last <= tl_last;
                  tl_data <= ram_data;
                  tl_last <= push_last;
               end else begin
                  hd_data <= ram_data;
                  hd_last <= push_last;
               end
            end
            2'b10: begin
               hd_valid <= tl_valid;
               tl_valid <= 1'b0;
               if (tl_valid) begin
                  hd_data <= tl_data;
                  hd_last <= tl_last;
               end else begin
                  hd_last <= 1'b0;
               end
            end
            2'b01: begin
               if (hd_valid) begin
                  tl_valid <= 1'b1;
                  tl_data  <= ram_data;
                  tl_last  <= push_last;
               end else begin
                  hd_valid <= 1'b1;
                  hd_data  <= ram_data;
                  hd_last  <= push_last;
               end
            end
            default: ;
         endcase

         case (state)
            IDLE: begin
               if (start && !done) begin
                  if (len_sat != '0) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     len_r     <= len_sat;
                     issued    <= '0;
                     captured  <= '0;
                     read_addr <= base_addr;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue && ((issued + 1'b1) == len_r))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (pop && hd_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural RAM, directed cases and random
// transfers checked against an address-order word queue.
module tb_bram_stream_reader;
   localparam int DW    = 128;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy, done;
   logic [AW-1:0] read_addr;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   bram_stream_reader_if #(.DATA_WIDTH(DW)) s ();

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .read_addr (read_addr),
      .ram_data  (ram_data),
      .m         (s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ram_data <= mem[read_addr];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_valid"}, s.valid, 1'b0);
      chk1({tag, "_last"}, s.last, 1'b0);
      chkw({tag, "_data"}, s.data, '0);
      chkw({tag, "_addr"}, DW'(read_addr), '0);
   endtask

   // mode: 0 ready held high, 1 ready pattern 1,0,0,1,0,1..., 2 random ready
   task automatic xfer(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                       input bit timed, input bit extra, input int abort_at);
      logic [DW-1:0] expq[$];
      logic [DW-1:0] held_data;
      logic          held_last, stalled, popped_last, exp_done, pop;
      logic [5:0]    pat;
      int            n, got;
      bit            finished;
      pat = 6'b101001;
      n = (int'(l) > DEPTH) ? DEPTH : int'(l);
      for (int i = 0; i < n; i++) expq.push_back(mem[AW'((int'(b) + i) % DEPTH)]);
      got = 0; stalled = 1'b0; popped_last = 1'b0; finished = 1'b0;
      held_data = '0; held_last = 1'b0;
      start = 1'b1; base_addr = b; len = l;
      step();
      start = 1'b0;
      for (int c = 1; c < 300; c++) begin
         case (mode)
            0:       s.ready = 1'b1;
            1:       s.ready = pat[3'(c % 6)];
            default: s.ready = ($urandom_range(0, 1) == 1);
         endcase
         if (extra) begin
            start = (c == 4);
            if (c == 4) begin base_addr = '0; len = 4'd2; end
         end
         exp_done = timed ? (c == 3 + n) : popped_last;
         chk1("done", done, exp_done);
         chk1("busy", busy, !exp_done);
         if (timed) chk1("valid_timing", s.valid, (c >= 3 && c < 3 + n));
         if (timed && c == 1) chkw("first_addr", DW'(read_addr), DW'(b));
         if (stalled) begin
            chk1("stall_valid", s.valid, 1'b1);
            chkw("stall_data", s.data, held_data);
            chk1("stall_last", s.last, held_last);
         end
         if (exp_done) begin
            finished = 1'b1;
            chk1("valid_after_done", s.valid, 1'b0);
            break;
         end
         pop = s.valid && s.ready;
         if (pop) begin
            if (expq.size() == 0) begin
               chk1("extra_beat", s.valid, 1'b0);
            end else begin
               chkw("beat_data", s.data, expq[0]);
               chk1("beat_last", s.last, expq.size() == 1);
               if (expq.size() == 1) popped_last = 1'b1;
               void'(expq.pop_front());
               got++;
            end
         end
         stalled   = s.valid && !s.ready;
         held_data = s.data;
         held_last = s.last;
         if (abort_at > 0 && got == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            chk_reset_outputs("mid_reset");
            step();
            step();
            rst_n = 1'b1;
            step();
            return;
         end
         step();
      end
      chk1("finished", finished, 1'b1);
      chkw("beat_count", DW'(got), DW'(n));
      if (extra) start = 1'b1;
      step();
      start = 1'b0;
      if (extra) chk1("start_during_done", busy, 1'b0);
   endtask

   initial begin
      s.ready = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_outputs("reset");
      step();
      step();
      rst_n = 1'b1;
      step();

      xfer(3'd0, 4'd8, 0, 1'b1, 1'b0, 0);

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16);
      xfer(3'd6, 4'd4, 0, 1'b1, 1'b0, 0);

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      xfer(3'd0, 4'd8, 1, 1'b0, 1'b0, 0);

      start = 1'b1; base_addr = 3'd5; len = '0;
      step();
      start = 1'b0;
      chk1("zero_done", done, 1'b1);
      chk1("zero_busy", busy, 1'b0);
      chk1("zero_valid", s.valid, 1'b0);
      step();
      chk1("zero_done_end", done, 1'b0);
      chk1("zero_busy_end", busy, 1'b0);
      chk1("zero_valid_end", s.valid, 1'b0);
      step();

      xfer(3'd3, 4'd15, 0, 1'b1, 1'b1, 0);

      xfer(3'd0, 4'd8, 0, 1'b1, 1'b0, 3);
      xfer(3'd0, 4'd2, 0, 1'b1, 1'b0, 0);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
         xfer(AW'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(1, 15)), 2, 1'b0, 1'b0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
